// File: rtl/fd_pkg.sv
// fd_pkg: shared constants and the radius-3 Bresenham circle offset table
// used by the fd_window_gen corner-detector front end.
package fd_pkg;

    localparam int WIN_SIZE      = 7;
    localparam int CIRCLE_PIXELS = 16;
    localparam int COORD_W       = 10;
    localparam int PIX_W         = 8;

    // Window centre index and the number of rows held in line buffers.
    localparam int WIN_HALF      = WIN_SIZE / 2;
    localparam int NUM_LB        = WIN_SIZE - 1;

    // Circle pixels 1..16, clockwise from 12 o'clock; y grows downward.
    localparam int CIRCLE_DX [CIRCLE_PIXELS] = '{
         0,  1,  2,  3,
         3,  3,  2,  1,
         0, -1, -2, -3,
        -3, -3, -2, -1
    };
    localparam int CIRCLE_DY [CIRCLE_PIXELS] = '{
        -3, -3, -2, -1,
         0,  1,  2,  3,
         3,  3,  2,  1,
         0, -1, -2, -3
    };

    function automatic int circle_row(input int idx);
        return WIN_HALF + CIRCLE_DY[idx];
    endfunction

    function automatic int circle_col(input int idx);
        return WIN_HALF + CIRCLE_DX[idx];
    endfunction

endpackage

// File: rtl/fd_line_buffer.sv
// fd_line_buffer: one image row of pixel storage, single read/write port.
// Read is combinational from the current address, so a same-address write returns the old data.
module fd_line_buffer
    import fd_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [PIX_W-1:0] wdata,
    output logic [PIX_W-1:0] rdata
);

    logic [PIX_W-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    // Contents are deliberately not reset; stale rows are masked by the window-valid logic.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/fd_window_gen.sv
// fd_window_gen: raster-stream 7x7 window generator emitting the centre pixel and 16 circle pixels.
// Define FD_FRAME_START_EN to add an sof input that forces the flagged pixel to row 0, col 0.
module fd_window_gen
    import fd_pkg::*;
#(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 48
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [PIX_W-1:0]                 pixelIn,
    input  logic                             pixelValid,
`ifdef FD_FRAME_START_EN
    input  logic                             sof,
`endif
    output logic [PIX_W-1:0]                 refPixel,
    output logic [CIRCLE_PIXELS*PIX_W-1:0]   adjPixel,
    output logic                             winValid,
    output logic [COORD_W-1:0]               xPos,
    output logic [COORD_W-1:0]               yPos
);

    localparam int LB_AW = $clog2(IMG_WIDTH);

    logic [COORD_W-1:0] col;
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col_cur;
    logic [COORD_W-1:0] row_cur;
    logic [COORD_W-1:0] col_nxt;
    logic [COORD_W-1:0] row_nxt;
    logic               sof_hit;
    logic               win_hit;

    logic [PIX_W-1:0] lb_rd [NUM_LB];
    logic [PIX_W-1:0] lb_wr [NUM_LB];

    logic [PIX_W-1:0] win      [WIN_SIZE][WIN_SIZE];
    logic [PIX_W-1:0] win_next [WIN_SIZE][WIN_SIZE];

    logic [PIX_W-1:0]               ref_next;
    logic [CIRCLE_PIXELS*PIX_W-1:0] adj_next;

`ifdef FD_FRAME_START_EN
    assign sof_hit = sof & pixelValid;
`else
    assign sof_hit = 1'b0;
`endif

    // Position of the pixel being accepted this cycle; sof overrides the running count.
    assign col_cur = sof_hit ? '0 : col;
    assign row_cur = sof_hit ? '0 : row;

    always_comb begin
        col_nxt = col_cur + COORD_W'(1);
        row_nxt = row_cur;
        if (col_cur == COORD_W'(IMG_WIDTH - 1)) begin
            col_nxt = '0;
            if (row_cur == COORD_W'(IMG_HEIGHT - 1)) begin
                row_nxt = '0;
            end else begin
                row_nxt = row_cur + COORD_W'(1);
            end
        end
    end

    // Only a window built entirely from the current frame's rows and columns is flagged.
    assign win_hit = pixelValid
                   && (row_cur >= COORD_W'(NUM_LB))
                   && (col_cur >= COORD_W'(NUM_LB));

    // Line buffers form a vertical shift chain: index 0 is the oldest (top) row.
    always_comb begin
        for (int k = 0; k < NUM_LB - 1; k++) begin
            lb_wr[k] = lb_rd[k + 1];
        end
        lb_wr[NUM_LB - 1] = pixelIn;
    end

    for (genvar k = 0; k < NUM_LB; k++) begin : g_lb
        fd_line_buffer #(
            .DEPTH (IMG_WIDTH)
        ) u_lb (
            .clk   (clk),
            .we    (pixelValid),
            .addr  (col_cur[LB_AW-1:0]),
            .wdata (lb_wr[k]),
            .rdata (lb_rd[k])
        );
    end

    always_comb begin
        for (int r = 0; r < WIN_SIZE; r++) begin
            for (int c = 0; c < WIN_SIZE; c++) begin
                win_next[r][c] = win[r][c];
            end
        end
        if (pixelValid) begin
            for (int r = 0; r < WIN_SIZE; r++) begin
                for (int c = 0; c < WIN_SIZE - 1; c++) begin
                    win_next[r][c] = win[r][c + 1];
                end
            end
            for (int r = 0; r < NUM_LB; r++) begin
                win_next[r][WIN_SIZE - 1] = lb_rd[r];
            end
            win_next[NUM_LB][WIN_SIZE - 1] = pixelIn;
        end
    end

    // Outputs are taken from the post-shift window so they register on the accepting edge.
    assign ref_next = win_next[WIN_HALF][WIN_HALF];

    for (genvar i = 0; i < CIRCLE_PIXELS; i++) begin : g_circle
        localparam int TAP_R = circle_row(i);
        localparam int TAP_C = circle_col(i);
        assign adj_next[(CIRCLE_PIXELS - 1 - i) * PIX_W +: PIX_W] = win_next[TAP_R][TAP_C];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col      <= '0;
            row      <= '0;
            winValid <= 1'b0;
            refPixel <= '0;
            adjPixel <= '0;
            xPos     <= '0;
            yPos     <= '0;
            for (int r = 0; r < WIN_SIZE; r++) begin
                for (int c = 0; c < WIN_SIZE; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else begin
            winValid <= win_hit;
            win      <= win_next;
            if (pixelValid) begin
                col <= col_nxt;
                row <= row_nxt;
            end
            if (win_hit) begin
                refPixel <= ref_next;
                adjPixel <= adj_next;
                xPos     <= col_cur - COORD_W'(WIN_HALF);
                yPos     <= row_cur - COORD_W'(WIN_HALF);
            end
        end
    end

endmodule

// File: tb/tb_fd_window_gen.sv
// tb_fd_window_gen: scoreboard bench; a frame-image model predicts every window, a monitor checks them.
// Define FD_FRAME_START_EN to also exercise the sof re-alignment input.
module tb_fd_window_gen;

    localparam int W = 16;
    localparam int H = 12;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [7:0]   pixelIn = 8'd0;
    logic         pixelValid = 1'b0;
`ifdef FD_FRAME_START_EN
    logic         sof = 1'b0;
`endif
    logic [7:0]   refPixel;
    logic [127:0] adjPixel;
    logic         winValid;
    logic [9:0]   xPos;
    logic [9:0]   yPos;

    fd_window_gen #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pixelIn    (pixelIn),
        .pixelValid (pixelValid),
`ifdef FD_FRAME_START_EN
        .sof        (sof),
`endif
        .refPixel   (refPixel),
        .adjPixel   (adjPixel),
        .winValid   (winValid),
        .xPos       (xPos),
        .yPos       (yPos)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]   refp;
        logic [127:0] adj;
        logic [9:0]   x;
        logic [9:0]   y;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         tests = 0;
    int         fails = 0;
    int         mr = 0;
    int         mc = 0;
    logic [7:0] img [H][W];
    int         odx [16] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
    int         ody [16] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};

    int           pulse_cnt = 0;
    int           since_sof = 0;
    bit           first_seen = 1'b0;
    logic [7:0]   first_ref;
    logic [127:0] first_adj;
    logic [9:0]   first_x;
    logic [9:0]   first_y;
    int           first_since_sof;
    bit           rec_en = 1'b0;
    logic [7:0]   rec_q[$];
    logic [7:0]   base_seq[$];
    logic         pv_last = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Model: remember the whole frame image and read windows from it by coordinates.
    task automatic issue(input bit v, input bit rnd, input bit s);
        logic [7:0] d;
        exp_t       e;
        @(posedge clk);
        #1;
        d = 8'($urandom);
        if (v) begin
            if (s) begin
                mr = 0;
                mc = 0;
                since_sof = 0;
            end else begin
                since_sof++;
            end
            if (!rnd) d = 8'((mr * 16 + mc) % 256);
            img[mr][mc] = d;
            if (mr >= 6 && mc >= 6) begin
                e.refp = img[mr - 3][mc - 3];
                e.adj  = '0;
                for (int i = 0; i < 16; i++) begin
                    e.adj[127 - 8 * i -: 8] = img[mr - 3 + ody[i]][mc - 3 + odx[i]];
                end
                e.x = 10'(mc - 3);
                e.y = 10'(mr - 3);
                exp_q.push_back(e);
            end
            mc++;
            if (mc == W) begin
                mc = 0;
                mr = (mr == H - 1) ? 0 : mr + 1;
            end
        end
        pixelValid = v;
        pixelIn    = d;
`ifdef FD_FRAME_START_EN
        sof        = s;
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_winValid"}, 128'(winValid), 128'(0));
        check({tag, "_refPixel"}, 128'(refPixel), 128'(0));
        check({tag, "_adjPixel"}, adjPixel, 128'(0));
        check({tag, "_xPos"}, 128'(xPos), 128'(0));
        check({tag, "_yPos"}, 128'(yPos), 128'(0));
    endtask

    task automatic reset_mid();
        #3;
        rst_n      = 1'b0;
        pixelValid = 1'b0;
`ifdef FD_FRAME_START_EN
        sof        = 1'b0;
`endif
        #1;
        check_zero("midreset");
        exp_q.delete();
        mr = 0;
        mc = 0;
        repeat (3) begin
            @(negedge clk);
            check("winValid_in_reset", 128'(winValid), 128'(0));
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic check_first(input string tag, input logic [7:0] rv);
        check({tag, "_seen"}, 128'(first_seen), 128'(1));
        check({tag, "_xPos"}, 128'(first_x), 128'(3));
        check({tag, "_yPos"}, 128'(first_y), 128'(3));
        check({tag, "_refPixel"}, 128'(first_ref), 128'(rv));
    endtask

    always @(negedge clk) begin
        if (rst_n && winValid) begin
            pulse_cnt++;
            check("winValid_after_idle", 128'(pv_last), 128'(1));
            if (!first_seen) begin
                first_seen      = 1'b1;
                first_ref       = refPixel;
                first_adj       = adjPixel;
                first_x         = xPos;
                first_y         = yPos;
                first_since_sof = since_sof;
            end
            if (rec_en) rec_q.push_back(refPixel);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_winValid: got pulse at x=%0d y=%0d, expected none", xPos, yPos);
            end else begin
                mon_e = exp_q.pop_front();
                check("refPixel", 128'(refPixel), 128'(mon_e.refp));
                check("adjPixel", adjPixel, mon_e.adj);
                check("xPos", 128'(xPos), 128'(mon_e.x));
                check("yPos", 128'(yPos), 128'(mon_e.y));
            end
        end
        pv_last = pixelValid;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int total;
        int accepted;
        int nmis;

        #2 rst_n = 1'b0;
        #2;
        check_zero("reset");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Two contiguous frames with the formula pixel values.
        first_seen = 1'b0;
        pulse_cnt  = 0;
        rec_en     = 1'b1;
        for (int i = 0; i < W * H; i++) issue(1'b1, 1'b0, 1'b0);
        idle(2);
        check("frame1_pulses", 128'(pulse_cnt), 128'(60));
        check_first("first_win", 8'd51);
        check("first_adj_p1", 128'(first_adj[127:120]), 128'(3));
        check("first_adj_p5", 128'(first_adj[95:88]), 128'(54));
        check("first_adj_p16", 128'(first_adj[7:0]), 128'(2));
        rec_en = 1'b0;
        base_seq = rec_q;
        rec_q.delete();
        total = pulse_cnt;
        pulse_cnt = 0;
        for (int i = 0; i < W * H; i++) issue(1'b1, 1'b0, 1'b0);
        idle(2);
        check("frame2_pulses", 128'(pulse_cnt), 128'(60));
        total += pulse_cnt;
        check("two_frame_pulses", 128'(total), 128'(120));

        // Alternating valid/idle must reproduce the contiguous output sequence.
        pulse_cnt = 0;
        rec_en    = 1'b1;
        for (int i = 0; i < W * H; i++) begin
            issue(1'b1, 1'b0, 1'b0);
            issue(1'b0, 1'b0, 1'b0);
        end
        idle(2);
        rec_en = 1'b0;
        check("gap_pulses", 128'(pulse_cnt), 128'(60));
        check("gap_seq_len", 128'(rec_q.size()), 128'(base_seq.size()));
        nmis = 0;
        for (int i = 0; i < rec_q.size() && i < base_seq.size(); i++) begin
            if (rec_q[i] !== base_seq[i]) nmis++;
        end
        check("gap_seq_data_mismatches", 128'(nmis), 128'(0));
        rec_q.delete();

        // Random pixel values with random idle cycles over two frames.
        pulse_cnt = 0;
        accepted  = 0;
        while (accepted < 2 * W * H) begin
            bit v;
            v = ($urandom_range(0, 9) < 7);
            issue(v, 1'b1, 1'b0);
            if (v) accepted++;
        end
        idle(2);
        check("random_pulses", 128'(pulse_cnt), 128'(120));

        // Reset mid-frame at row 8, col 5, then a fresh frame.
        while (!(mr == 8 && mc == 5)) issue(1'b1, 1'b0, 1'b0);
        issue(1'b0, 1'b0, 1'b0);
        reset_mid();
        first_seen = 1'b0;
        pulse_cnt  = 0;
        for (int i = 0; i < W * H; i++) issue(1'b1, 1'b0, 1'b0);
        idle(2);
        check_first("restart", 8'd51);
        check("restart_pulses", 128'(pulse_cnt), 128'(60));

`ifdef FD_FRAME_START_EN
        // sof on the 40th pixel; sof with pixelValid low in between must be ignored.
        for (int i = 0; i < 39; i++) issue(1'b1, 1'b0, 1'b0);
        idle(2);
        first_seen = 1'b0;
        issue(1'b1, 1'b0, 1'b1);
        issue(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 120; i++) begin
            issue(1'b1, 1'b0, 1'b0);
            if (i == 20) issue(1'b0, 1'b0, 1'b1);
        end
        idle(2);
        check_first("sof", 8'd51);
        check("sof_first_latency", 128'(first_since_sof), 128'(102));
`endif

        check("leftover_expected", 128'(exp_q.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fd_window_gen.md
FD_WINDOW_GEN -- requirements
Module: fd_window_gen

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 64: pixels per row, 8..1023.
REQ-002 SHALL have parameter IMG_HEIGHT, default 48: rows per frame, 8..1023.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port pixelIn, input, 8 bits: raster-order pixel, left-to-right then top-to-bottom.
REQ-006 SHALL have port pixelValid, input, 1 bit: pixelIn is accepted on this edge.
REQ-007 SHALL have port refPixel, output, 8 bits: centre pixel of the 7x7 window.
REQ-008 SHALL have port adjPixel, output, 128 bits: the 16 Bresenham circle pixels, radius 3; pixel 1 occupies [127:120] and pixel 16 occupies [7:0].
REQ-009 SHALL have port winValid, output, 1 bit: refPixel, adjPixel, xPos and yPos are valid this cycle.
REQ-010 SHALL have ports xPos and yPos, output, 10 bits each: column and row of the centre pixel.

Function
REQ-011 SHALL keep counters col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1), advancing only on pixelValid.
- col wraps to 0 and increments row.
- row wraps to 0 after IMG_HEIGHT-1.
REQ-012 SHALL keep six row line buffers, each IMG_WIDTH deep and 8 bits wide.
- On each accepted pixel, the column at address col shifts up one row and pixelIn is written to the bottom row.
REQ-013 SHALL keep a 7x7 register window. On each accepted pixel it shifts one column left; the new right column is {6 line-buffer outputs at col, pixelIn}, top row to bottom row.
REQ-014 SHALL, with window centre C=(dx,dy)=(0,0) and y increasing downward, map circle pixels 1..16 as follows:
- 1..4: (0,-3) (1,-3) (2,-2) (3,-1)
- 5..8: (3,0) (3,1) (2,2) (1,3)
- 9..12: (0,3) (-1,3) (-2,2) (-3,1)
- 13..16: (-3,0) (-3,-1) (-2,-2) (-1,-3)
REQ-015 SHALL assert winValid for exactly one cycle, the cycle after accepting a pixel with row>=6 and col>=6.
- Outputs are registered, giving a latency of 1 cycle.
- xPos=col-3 and yPos=row-3 of that pixel.
REQ-016 SHALL hold winValid low during the first 6 rows and first 6 columns of every frame, including after a frame wrap. Stale line-buffer and window data from the previous row or frame is never flagged valid.
REQ-017 SHALL, on a cycle with pixelValid low, hold counters, window and line buffers; winValid is 0 the next cycle and the data outputs hold their values.
REQ-018 SHALL produce exactly (IMG_WIDTH-6)*(IMG_HEIGHT-6) winValid pulses per frame.
REQ-019 SHALL accept one pixel per cycle with no backpressure and no ready signal.

Reset
REQ-020 SHALL, while rst_n=0, clear col, row, winValid, refPixel, adjPixel, xPos, yPos and the window registers to 0 immediately.
REQ-021 SHALL NOT clear line-buffer contents on reset; that stale data is masked by REQ-016.
REQ-022 SHALL restart at row 0, col 0 when reset is released mid-frame.

Configuration
REQ-023 SHALL, with FD_FRAME_START_EN defined, add input sof (1 bit). When sof=1 with pixelValid=1, that pixel is taken as row 0, col 0, and counting continues from it; sof with pixelValid=0 is ignored.
REQ-024 SHALL, without FD_FRAME_START_EN, have no sof port; frame alignment comes from reset and counter wrap only.

Structure
REQ-025 SHALL place the constants WIN_SIZE=7, CIRCLE_PIXELS=16 and COORD_W=10, plus the circle offset table, in the shared package fd_pkg.
REQ-026 SHALL implement each line buffer as sub-module fd_line_buffer (depth IMG_WIDTH, 8 bits wide, 1 read/write port, same-address read-before-write), instantiated 6 times.

Verification
Common bench setup: IMG_WIDTH=16, IMG_HEIGHT=12, and pixel value = (row*16+col) mod 256.
REQ-027 SHALL cover reset: assert rst_n=0 mid-stream -> all outputs 0 immediately and winValid stays 0.
REQ-028 SHALL cover the first window: a contiguous stream -> first winValid one cycle after accepting pixel (6,6), with refPixel=51, xPos=3, yPos=3, adjPixel[127:120]=3, adjPixel[95:88] (pixel 5)=54, adjPixel[7:0]=2.
REQ-029 SHALL cover frame counts: two full frames -> 60 winValid pulses per frame, 120 in total; none fire while row<6 or col<6 in frame 2.
REQ-030 SHALL cover input gaps: pixelValid toggled 1,0,1,0... -> output data sequence identical to the contiguous run, and winValid is never high the cycle after an idle cycle.
REQ-031 SHALL cover restart: reset at row 8, col 5, then a fresh frame -> first winValid again at xPos=3, yPos=3 with refPixel=51.
REQ-032 SHALL cover FD_FRAME_START_EN: sof at the 40th pixel of a frame -> that pixel becomes (0,0), and the first winValid comes 102 accepted pixels later with xPos=3, yPos=3.
